// File: rtl/dugum_seviye_yolu.sv
// dugum_seviye_yolu: iterative heap-node level finder with optional node->root path streaming
// Level is found by halving (node+1) until it reaches 1; path beats walk parent links back to 0.
module dugum_seviye_yolu #(
    parameter int W        = 4,
    parameter int SEVIYE_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_dugum,
    input  logic                in_yol_modu,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_dugum,
    output logic [SEVIYE_W-1:0] out_seviye,
    output logic                out_son,
    output logic                mesgul
);
    typedef enum logic [1:0] {BOS, HESAP, CIKIS} durum_t;

    durum_t              state_q, state_d;
    logic [W:0]          m_q, m_d;
    logic [W-1:0]        node_q, node_d;
    logic [SEVIYE_W-1:0] lvl_q, lvl_d;
    logic                mode_q, mode_d;
    logic                son;

    assign son = !mode_q || (lvl_q == '0);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        node_d  = node_q;
        lvl_d   = lvl_q;
        mode_d  = mode_q;
        unique case (state_q)
            BOS: if (in_valid) begin
                m_d     = {1'b0, in_dugum} + (W+1)'(1);
                node_d  = in_dugum;
                lvl_d   = '0;
                mode_d  = in_yol_modu;
                state_d = HESAP;
            end
            HESAP: if (m_q > (W+1)'(1)) begin
                m_d   = m_q >> 1;
                lvl_d = lvl_q + 1'b1;
            end else begin
                state_d = CIKIS;
            end
            CIKIS: if (out_ready) begin
                if (son) begin
                    state_d = BOS;
                end else begin
                    node_d = (node_q - 1'b1) >> 1;
                    lvl_d  = lvl_q - 1'b1;
                end
            end
            default: state_d = BOS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOS;
            m_q     <= '0;
            node_q  <= '0;
            lvl_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            node_q  <= node_d;
            lvl_q   <= lvl_d;
            mode_q  <= mode_d;
        end
    end

    // Every output decodes flops only; in_ready is the sole state decode seen by the source.
    assign in_ready   = (state_q == BOS);
    assign out_valid  = (state_q == CIKIS);
    assign out_dugum  = node_q;
    assign out_seviye = lvl_q;
    assign out_son    = out_valid && son;
    assign mesgul     = (state_q != BOS);
endmodule

// File: tb/tb_dugum_seviye_yolu.sv
// tb_dugum_seviye_yolu: directed checks on a W=4 and a W=8 instance sharing clock and reset
module tb_dugum_seviye_yolu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic iv = 1'b0;
    logic imode = 1'b0;
    logic ordy = 1'b0;
    logic [7:0] idug = '0;
    int checks = 0;
    int errors = 0;

    logic a_ir, a_ov, a_son, a_mes;
    logic [3:0] a_dug;
    logic [2:0] a_sev;
    logic b_ir, b_ov, b_son, b_mes;
    logic [7:0] b_dug;
    logic [3:0] b_sev;

    always #5 clk = ~clk;

    dugum_seviye_yolu #(.W(4), .SEVIYE_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && !sel), .in_ready(a_ir),
        .in_dugum(idug[3:0]), .in_yol_modu(imode), .out_valid(a_ov), .out_ready(ordy && !sel),
        .out_dugum(a_dug), .out_seviye(a_sev), .out_son(a_son), .mesgul(a_mes));

    dugum_seviye_yolu #(.W(8), .SEVIYE_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel), .in_ready(b_ir),
        .in_dugum(idug), .in_yol_modu(imode), .out_valid(b_ov), .out_ready(ordy && sel),
        .out_dugum(b_dug), .out_seviye(b_sev), .out_son(b_son), .mesgul(b_mes));

    wire       o_ir  = sel ? b_ir  : a_ir;
    wire       o_ov  = sel ? b_ov  : a_ov;
    wire       o_son = sel ? b_son : a_son;
    wire       o_mes = sel ? b_mes : a_mes;
    wire [7:0] o_dug = sel ? b_dug : {4'b0, a_dug};
    wire [7:0] o_sev = sel ? {4'b0, b_sev} : {5'b0, a_sev};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accepts one request and returns how many edges after the accepting edge out_valid rose.
    task automatic send(input logic s, input int n, input logic m, output int edges);
        @(negedge clk);
        sel = s; idug = 8'(n); imode = m; iv = 1'b1; ordy = 1'b0;
        chk("in_ready_idle", int'(o_ir), 1);
        @(posedge clk);
        #1 iv = 1'b0;
        edges = 0;
        while (!o_ov && edges < 40) begin
            chk("busy_in_ready", int'(o_ir), 0);
            @(posedge clk);
            #1 edges++;
        end
        if (!o_ov) chk("out_valid_timeout", 0, 1);
    endtask

    // Walks expected beats starting at (n, l); stalls randomly when rnd is set.
    task automatic drain(input int n, input int l, input logic m, input logic rnd);
        int node = n;
        int lvl = l;
        bit last = 1'b0;
        while (!last) begin
            last = !m || lvl == 0;
            chk("beat_valid", int'(o_ov), 1);
            chk("beat_dugum", int'(o_dug), node);
            chk("beat_seviye", int'(o_sev), lvl);
            chk("beat_son", int'(o_son), int'(last));
            chk("beat_mesgul", int'(o_mes), 1);
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    ordy = 1'b0;
                    @(posedge clk);
                    #1;
                    chk("stall_valid", int'(o_ov), 1);
                    chk("stall_dugum", int'(o_dug), node);
                    chk("stall_seviye", int'(o_sev), lvl);
                    chk("stall_in_ready", int'(o_ir), 0);
                end
            end
            ordy = 1'b1;
            @(posedge clk);
            #1 ordy = 1'b0;
            node = (node - 1) / 2;
            lvl--;
        end
        chk("done_in_ready", int'(o_ir), 1);
        chk("done_valid", int'(o_ov), 0);
    endtask

    int lv4[16] = '{0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4};
    int e;

    initial begin
        #1;
        chk("rst_valid", int'(a_ov), 0);
        chk("rst_in_ready", int'(a_ir), 1);
        chk("rst_dugum", int'(a_dug), 0);
        chk("rst_seviye", int'(a_sev), 0);
        chk("rst_son", int'(a_son), 0);
        chk("rst_mesgul", int'(a_mes), 0);
        iv = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("rst_ignores_valid", int'(a_mes), 0);
        iv = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        send(0, 0, 0, e); chk("t1_latency", e, 1); drain(0, 0, 0, 0);
        send(0, 6, 0, e); chk("t2_latency", e, 3); drain(6, 2, 0, 0);
        for (int n = 0; n < 16; n++) begin
            send(0, n, 0, e);
            chk("t2_sweep_latency", e, lv4[n] + 1);
            drain(n, lv4[n], 0, 0);
        end
        send(0, 15, 1, e); chk("t3_latency", e, 5); drain(15, 4, 1, 0);
        send(0, 10, 1, e); chk("t4_latency", e, 4); drain(10, 3, 1, 1);
        send(0, 0, 1, e); drain(0, 0, 1, 0);
        send(0, 15, 1, e);
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        chk("t5_second_beat", int'(o_dug), 7);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(o_ov), 0);
        chk("t5_rst_in_ready", int'(o_ir), 1);
        chk("t5_rst_mesgul", int'(o_mes), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("t5_no_partial", int'(o_ov), 0);
        send(0, 2, 0, e); chk("t5_latency", e, 2); drain(2, 1, 0, 0);
        send(1, 255, 0, e); chk("t6_latency_255", e, 9); drain(255, 8, 0, 0);
        send(1, 127, 0, e); chk("t6_latency_127", e, 8); drain(127, 7, 0, 0);
        send(1, 255, 1, e); drain(255, 8, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
